// File: rtl/ascii_scan_ctrl_if.sv
// Host write/load bus and decoder drive outputs of ascii_scan_ctrl.
interface ascii_scan_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic              i_we;
    logic [2:0]        i_wa;
    logic [6:0]        i_wd;
    logic              i_wb;
    logic              i_load;
    logic              o_pend;
    logic              o_frame;
    logic [6:0]        o_d;
    logic              o_abi;
    logic [DIGITS-1:0] o_dig;

    modport master (
        output i_we, i_wa, i_wd, i_wb, i_load,
        input  o_pend, o_frame, o_d, o_abi, o_dig
    );

    modport slave (
        input  i_we, i_wa, i_wd, i_wb, i_load,
        output o_pend, o_frame, o_d, o_abi, o_dig
    );
endinterface

// File: rtl/ascii_scan_ctrl.sv
// Double-buffered, time-multiplexed scanner feeding one shared ascii_decoder.
// Optional per-digit blink is enabled by defining ASCII_SCAN_BLINK_EN.
module ascii_scan_ctrl #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned PRESCALE  = 1024,
    parameter int unsigned DEAD      = 16,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    ascii_scan_ctrl_if.slave  bus
);

    localparam int unsigned CW = $clog2(PRESCALE);
    localparam int unsigned IW = $clog2(DIGITS);
`ifdef ASCII_SCAN_BLINK_EN
    localparam int unsigned EW = 8;
`else
    localparam int unsigned EW = 7;
`endif
    localparam logic [EW-1:0] SPACE = EW'(7'h20);

    typedef enum logic {BLANK, SHOW} phase_t;

    logic [CW-1:0]     r_cyc;
    logic [IW-1:0]     r_idx;
    phase_t            r_phase;
    logic [EW-1:0]     r_shadow [DIGITS];
    logic [EW-1:0]     r_active [DIGITS];
    logic              r_pend;
    logic              r_frame;
    logic [6:0]        r_d;
    logic              r_abi;
    logic [DIGITS-1:0] r_dig;

    logic          w_boundary;
    logic          w_copy;
    logic          w_cyc_last;
    logic          w_idx_last;
    logic          w_wr_ok;
    logic [EW-1:0] w_wr_entry;
    logic          w_blink_off;

    // r_cyc/r_idx name the slot position being emitted on the next edge
    assign w_boundary = (r_cyc == '0) && (r_idx == '0);
    assign w_copy     = w_boundary && r_pend;
    assign w_cyc_last = (r_cyc == CW'(PRESCALE - 1));
    assign w_idx_last = (r_idx == IW'(DIGITS - 1));
    assign w_wr_ok    = bus.i_we && ({1'b0, bus.i_wa} < 4'(DIGITS));

`ifdef ASCII_SCAN_BLINK_EN
    localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [FW-1:0] r_fcnt;
    logic          r_boff;

    assign w_wr_entry  = {bus.i_wb, bus.i_wd};
    assign w_blink_off = r_boff && r_active[r_idx][7];

    // Blink phase flips after every BLINK_DIV complete frames
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fcnt <= '0;
            r_boff <= 1'b0;
        end else if (w_cyc_last && w_idx_last) begin
            if (r_fcnt == FW'(BLINK_DIV - 1)) begin
                r_fcnt <= '0;
                r_boff <= ~r_boff;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end
`else
    logic w_unused_blink;

    assign w_wr_entry     = bus.i_wd;
    assign w_blink_off    = 1'b0;
    assign w_unused_blink = bus.i_wb ^ (BLINK_DIV == 0);
`endif

    // Slot counter, digit index and blank/show phase
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc   <= '0;
            r_idx   <= '0;
            r_phase <= BLANK;
        end else begin
            r_cyc <= w_cyc_last ? '0 : r_cyc + CW'(1);
            if (w_cyc_last) begin
                r_idx <= w_idx_last ? '0 : r_idx + IW'(1);
            end
            case (r_phase)
                BLANK:   if (r_cyc == CW'(DEAD - 1)) r_phase <= SHOW;
                SHOW:    if (w_cyc_last)             r_phase <= BLANK;
                default: r_phase <= BLANK;
            endcase
        end
    end

    // Shadow/active store; the copy samples shadow before a same-edge write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                r_shadow[i] <= SPACE;
                r_active[i] <= SPACE;
            end
            r_pend <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_shadow[IW'(bus.i_wa)] <= w_wr_entry;
            end
            if (w_copy) begin
                r_active <= r_shadow;
            end
            r_pend <= w_copy ? 1'b0 : (r_pend | bus.i_load);
        end
    end

    // Registered decoder drive
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame <= 1'b0;
            r_d     <= 7'h20;
            r_abi   <= 1'b0;
            r_dig   <= '0;
        end else begin
            r_frame <= w_boundary;
            if (r_cyc == '0) begin
                r_d <= w_copy ? r_shadow[0][6:0] : r_active[r_idx][6:0];
            end
            r_dig <= (r_phase == SHOW) ? (DIGITS'(1) << r_idx) : '0;
            r_abi <= (r_phase == SHOW) && !w_blink_off;
        end
    end

    assign bus.o_pend  = r_pend;
    assign bus.o_frame = r_frame;
    assign bus.o_d     = r_d;
    assign bus.o_abi   = r_abi;
    assign bus.o_dig   = r_dig;

endmodule

// File: tb/tb_ascii_scan_ctrl.sv
// Directed plus random bench for ascii_scan_ctrl against a position-based reference model.
module tb_ascii_scan_ctrl;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned PRESCALE  = 8;
    localparam int unsigned DEAD      = 2;
    localparam int unsigned BLINK_DIV = 2;
    localparam int unsigned FRAME_LEN = DIGITS * PRESCALE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ascii_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    ascii_scan_ctrl #(
        .DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEAD(DEAD), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    logic [7:0]  sh_m [DIGITS];
    logic [7:0]  ac_m [DIGITS];
    logic        pend_m;
    int unsigned t;
    logic [6:0]  exp_d;
    logic        exp_frame;
    logic        exp_abi;
    logic [3:0]  exp_dig;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic model_reset();
        for (int i = 0; i < int'(DIGITS); i++) begin
            sh_m[i] = 8'h20;
            ac_m[i] = 8'h20;
        end
        pend_m    = 1'b0;
        t         = 0;
        exp_d     = 7'h20;
        exp_frame = 1'b0;
        exp_abi   = 1'b0;
        exp_dig   = 4'b0000;
    endtask

    // Expected outputs for display position t, derived from slot arithmetic
    task automatic model_edge();
        int unsigned c, s, f;
        bit copy, blink_off;
        c = t % PRESCALE;
        s = (t / PRESCALE) % DIGITS;
        f = t / FRAME_LEN;
        exp_frame = (t % FRAME_LEN) == 0;
        copy = exp_frame && pend_m;
        if (c == 0) exp_d = copy ? sh_m[0][6:0] : ac_m[s][6:0];
        if (copy) for (int i = 0; i < int'(DIGITS); i++) ac_m[i] = sh_m[i];
        pend_m = copy ? 1'b0 : (pend_m | bus.i_load);
        if (bus.i_we && (32'(bus.i_wa) < DIGITS)) sh_m[32'(bus.i_wa)] = {bus.i_wb, bus.i_wd};
        exp_dig = (c >= DEAD) ? 4'(1 << s) : 4'b0000;
`ifdef ASCII_SCAN_BLINK_EN
        blink_off = (((f / BLINK_DIV) % 2) == 1) && ac_m[s][7];
`else
        blink_off = 1'b0;
`endif
        exp_abi = (c >= DEAD) && !blink_off;
        t++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp_v, t);
        end
    endtask

    task automatic check_all();
        check("frame", 32'(bus.o_frame), 32'(exp_frame));
        check("d",     32'(bus.o_d),     32'(exp_d));
        check("dig",   32'(bus.o_dig),   32'(exp_dig));
        check("abi",   32'(bus.o_abi),   32'(exp_abi));
        check("pend",  32'(bus.o_pend),  32'(pend_m));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the next position to be emitted satisfies t % m == v
    task automatic wait_pos(input int unsigned m, input int unsigned v);
        int k = 0;
        while ((t % m) != v && k < 200) begin
            tick();
            k++;
        end
        if ((t % m) != v) begin
            n_cmp++;
            n_err++;
            $error("FAIL wait_pos observed=%0d expected=%0d", t % m, v);
        end
    endtask

    task automatic write(input logic [2:0] a, input logic [6:0] d, input logic b);
        bus.i_we = 1'b1; bus.i_wa = a; bus.i_wd = d; bus.i_wb = b;
        tick();
        bus.i_we = 1'b0; bus.i_wb = 1'b0;
    endtask

    task automatic pulse_load();
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
    endtask

    initial begin
        bus.i_we = 1'b0; bus.i_wa = 3'd0; bus.i_wd = 7'd0; bus.i_wb = 1'b0; bus.i_load = 1'b0;
        model_reset();

        // Reset values, then first frame after release
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        tick();
        check("first_frame", 32'(bus.o_frame), 32'd1);
        check("first_d", 32'(bus.o_d), 32'h20);
        run(2);
        check("first_show_dig", 32'(bus.o_dig), 32'b0001);
        run(70);

        // Write ABCD, load mid-frame
        for (int i = 0; i < 4; i++) write(3'(i), 7'(8'h41 + i), 1'b0);
        run(40);
        check("no_load_d", 32'(bus.o_d), 32'h20);
        wait_pos(FRAME_LEN, 10);
        pulse_load();
        check("pend_set", 32'(bus.o_pend), 32'd1);
        wait_pos(FRAME_LEN, 1);
        check("pend_clr", 32'(bus.o_pend), 32'd0);
        check("load_d0", 32'(bus.o_d), 32'h41);
        run(FRAME_LEN);

        // Ignored address
        write(3'd5, 7'h5A, 1'b0);
        pulse_load();
        run(2 * FRAME_LEN);

        // Write on the copy edge uses old shadow
        pulse_load();
        wait_pos(FRAME_LEN, 0);
        write(3'd0, 7'h31, 1'b0);
        check("copy_old_d", 32'(bus.o_d), 32'h41);
        pulse_load();
        wait_pos(FRAME_LEN, 1);
        check("second_load_d", 32'(bus.o_d), 32'h31);

        // Blink attribute on digit 2
        write(3'd2, 7'h43, 1'b1);
        pulse_load();
        run(8 * FRAME_LEN);

        // Reset mid-slot with a pending load
        pulse_load();
        check("pend_before_rst", 32'(bus.o_pend), 32'd1);
        wait_pos(PRESCALE, 5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_release_frame", 32'(bus.o_frame), 32'd1);
        check("rst_release_pend", 32'(bus.o_pend), 32'd0);
        check("rst_release_d", 32'(bus.o_d), 32'h20);

        // Random traffic
        for (int i = 0; i < 900; i++) begin
            bus.i_we   = ($urandom_range(0, 2) == 0);
            bus.i_wa   = 3'($urandom);
            bus.i_wd   = 7'($urandom);
            bus.i_wb   = 1'($urandom);
            bus.i_load = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.i_we = 1'b0; bus.i_load = 1'b0;
        run(2 * FRAME_LEN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ascii_scan_ctrl.md
# ascii_scan_ctrl

Time-multiplexed display scanner that shares a single `ascii_decoder` instance between up to eight digit positions. It holds a double-buffered character store: the host writes a shadow buffer, and a load request copies it to the active buffer at the next frame boundary. It then steps through the active buffer one digit slot at a time. For each slot it drives the decoder's `D6..D0` and `ABI` inputs and a one-hot digit enable, with a dead-time blank at the start of each slot to suppress ghosting.

## Interface
- `DIGITS`, 4: number of digit positions, 2..8.
- `PRESCALE`, 1024: clock cycles per digit slot, at least `DEAD`+1.
- `DEAD`, 16: blanked cycles at the start of each slot, at least 1.
- `BLINK_DIV`, 64: blink half-period, in frames (only with `ASCII_SCAN_BLINK_EN`).

- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `WE` in 1: shadow write strobe, one entry per cycle.
- `WA` in 3: write address; values ≥ `DIGITS` are ignored.
- `WD` in 7: ASCII code written to `shadow[WA]`.
- `WB` in 1: blink attribute written with `WD`.
- `LOAD` in 1: request a copy from shadow to active at the next frame boundary.
- `PEND` out 1: load request outstanding.
- `FRAME` out 1: one-cycle pulse on the first cycle of slot 0.
- `D` out 7: character to the decoder `D6..D0`; registered.
- `ABI` out 1: blanking input to the decoder; 0 means blank.
- `DIG` out `DIGITS`: one-hot digit enable, active-high; all-zero while blanked.

## Operation
- Counters:
  - Slot counter `cyc` runs 0..`PRESCALE`-1.
  - Digit index `idx` runs 0..`DIGITS`-1 and advances when `cyc` wraps; it wraps to 0 after the last digit.
  - One frame = `DIGITS` slots.
- Phase FSM, two states:
  - `BLANK` while `cyc` < `DEAD`.
  - `SHOW` while `cyc` ≥ `DEAD`.
  - `BLANK`→`SHOW` when `cyc` = `DEAD`-1. `SHOW`→`BLANK` when `cyc` = `PRESCALE`-1.
- Outputs by phase:
  - In `BLANK`: `DIG`=0, `ABI`=0.
  - In `SHOW`: `DIG`=1<<`idx`, `ABI`=1 (subject to blink).
  - `D` is loaded with `active[idx]` on the first `BLANK` cycle of each slot and held for the whole slot.
- Writes: when `WE`=1 and `WA` < `DIGITS`, `shadow[WA]` ← {`WB`,`WD`} at the clock edge. Writes never touch the active buffer directly.
- Load sequence:
  - `LOAD`=1 sets `PEND` on the next edge.
  - At the frame boundary (`idx`=0, `cyc`=0) with `PEND`=1: active ← shadow, `PEND` clears, and `D` takes the new `active[0]` in that same cycle.
  - `LOAD` asserted while `PEND`=1 has no further effect.
  - `LOAD` asserted on the boundary cycle itself is serviced at the following frame.
  - `WE` in the same cycle as the copy: the copy uses the shadow contents from before the write.
- Reset:
  - Shadow and active entries = 0x20 (space) with blink=0.
  - `cyc`=0, `idx`=0, `D`=0x20, `ABI`=0, `DIG`=0, `PEND`=0, `FRAME`=0.
  - Reset asserted mid-slot forces these values immediately and discards any pending load.
  - The first cycle after release is slot 0, `cyc`=0, `FRAME`=1.

## Timing
- `PEND` rises 1 cycle after `LOAD`. Load latency is at most `DIGITS`×`PRESCALE`+1 cycles.
- A write is visible on `D` no earlier than the first frame boundary after both the write and a `LOAD` have completed.
- `FRAME` is high exactly when `idx`=0 and `cyc`=0.
- `DIG` pattern per slot: `DEAD` cycles of zero, then `PRESCALE`-`DEAD` cycles one-hot.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `ASCII_SCAN_BLINK_EN` defined:
  - A frame counter toggles the blink phase every `BLINK_DIV` frames, at the frame boundary; the phase resets to "on".
  - In the "off" phase, `ABI`=0 during `SHOW` for digits whose blink bit is 1. `DIG` is unaffected.
- `ASCII_SCAN_BLINK_EN` undefined:
  - `WB` is ignored and no blink bit is stored.
  - There is no frame counter.
  - `ABI`=1 throughout `SHOW`.

## Test plan
All scenarios use `DIGITS`=4, `PRESCALE`=8, `DEAD`=2, `BLINK_DIV`=2.

- **Reset.** Reset, then release → `FRAME`=1 on the first cycle, `D`=0x20, `DIG`=0000 for 2 cycles, then 0001 for 6 cycles, then 0010, and so on. The frame repeats every 32 cycles.
- **Write and load.** Write "ABCD" to addresses 0..3, then pulse `LOAD` mid-frame → `PEND`=1 until the next `FRAME`. Slots then show `D`=0x41, 0x42, 0x43, 0x44; without `LOAD`, `D` stays 0x20.
- **Ignored address.** Write 0x5A to `WA`=5, then `LOAD` → no entry changes.
- **Write during copy.** `WE` with `WA`=0, `WD`=0x31 in the same cycle as the frame-boundary copy → `D`=old `shadow[0]` this frame. A second `LOAD` shows 0x31.
- **Blink (macro on).** `WB`=1 on digit 2 → digit 2's `ABI` is 0 during `SHOW` in frames 2–3 and 6–7, and 1 in frames 0–1 and 4–5. Other digits are always 1. With the macro off, `ABI` is always 1.
- **Reset mid-slot.** Assert `RST_N`=0 at `cyc`=4 with `PEND`=1 → outputs go to reset values asynchronously and `PEND`=0 after release.
